// File: rtl/apb_mem_slave.sv
// ============================================================================
// apb_mem_slave : APB3 completer with word-addressed register memory,
//                 programmable wait states and out-of-range error response.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module apb_mem_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    addr_q;
  logic                write_q;
  logic                err_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                setup_err;
  logic [IDX_W-1:0]    setup_idx;

  // Widen both sides so no address bit is lost in the range check.
  assign setup_err = ({32'd0, PADDR} >= {{ADDR_W{1'b0}}, 32'(DEPTH)});
  assign setup_idx = PADDR[IDX_W-1:0];

  assign PREADY  = (state_q == S_ACCESS) && (cnt_q == '0);
  assign PSLVERR = PREADY && err_q;
  assign PRDATA  = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (PSEL && !PENABLE) begin
            state_q <= S_ACCESS;
            addr_q  <= setup_idx;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            err_q   <= setup_err;
            cnt_q   <= CNT_W'(WAIT_STATES);
            rdata_q <= setup_err ? '0 : mem_q[setup_idx];
          end
        end
        S_ACCESS: begin
          if (!PSEL) begin
            state_q <= S_IDLE;
          end else if (PENABLE) begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end else begin
              if (write_q && !err_q) begin
                mem_q[addr_q] <= wdata_q;
              end
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb_mem_slave.sv
// ============================================================================
// tb_apb_mem_slave : directed scoreboard bench for apb_mem_slave, covering a
//                    zero-wait and a two-wait-state instance on one bus.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite, sel2;
  logic [31:0] paddr, pwdata;
  logic        psel0, psel2;
  logic [31:0] prdata0, prdata2, prdata;
  logic        pready0, pready2, pready;
  logic        pslverr0, pslverr2, pslverr;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        rd;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Only the selected instance sees PSEL; the other stays idle.
  assign psel0   = psel & ~sel2;
  assign psel2   = psel & sel2;
  assign pready  = sel2 ? pready2  : pready0;
  assign prdata  = sel2 ? prdata2  : prdata0;
  assign pslverr = sel2 ? pslverr2 : pslverr0;

  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .PADDR(paddr), .PSEL(psel0), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0),
    .PSLVERR(pslverr0)
  );

  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .rst(rst), .PADDR(paddr), .PSEL(psel2), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata2), .PREADY(pready2),
    .PSLVERR(pslverr2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One full transfer; returns right after the PREADY=1 cycle is sampled so
  // the next call can issue a back-to-back setup phase.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input int exp_ws, input logic [31:0] exp_data, input logic exp_err,
                      input string tag);
    int   waits;
    exp_t e;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    sb.push_back('{rd: !wr, data: exp_data, err: exp_err});
    @(negedge clk);
    penable = 1'b1;
    paddr   = 32'hFFFF_FFFF;
    pwdata  = 32'hDEAD_BEEF;
    waits   = 0;
    while (pready !== 1'b1 && waits <= 50) begin
      @(negedge clk);
      waits++;
    end
    check({tag, "_waits"}, waits, exp_ws);
    e = sb.pop_front();
    check({tag, "_pslverr"}, {31'd0, pslverr}, {31'd0, e.err});
    if (e.rd) check({tag, "_prdata"}, prdata, e.data);
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    check({tag, "_pready_low"}, {31'd0, pready}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; sel2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pready0",  {31'd0, pready0},  32'd0);
    check("rst_pslverr0", {31'd0, pslverr0}, 32'd0);
    check("rst_prdata0",  prdata0,           32'd0);
    check("rst_pready2",  {31'd0, pready2},  32'd0);
    check("rst_prdata2",  prdata2,           32'd0);
    rst = 1'b0;

    // Zero-wait basic traffic
    xfer(1'b1, 32'd1, 32'd7, 0, 32'd0, 1'b0, "ws0_w1");
    xfer(1'b1, 32'd2, 32'd3, 0, 32'd0, 1'b0, "ws0_w2");
    xfer(1'b0, 32'd1, 32'd0, 0, 32'd7, 1'b0, "ws0_r1");
    xfer(1'b0, 32'd2, 32'd0, 0, 32'd3, 1'b0, "ws0_r2");
    idle_cycle("ws0_drop");

    // Out of range
    xfer(1'b1, 32'd16, 32'd9, 0, 32'd0, 1'b1, "oor_w16");
    xfer(1'b0, 32'd16, 32'd0, 0, 32'd0, 1'b1, "oor_r16");
    xfer(1'b0, 32'd0,  32'd0, 0, 32'd0, 1'b0, "oor_r0");
    xfer(1'b0, 32'h8000_0001, 32'd0, 0, 32'd0, 1'b1, "oor_rhigh");
    idle_cycle("oor_drop");

    // Back-to-back write then read
    xfer(1'b1, 32'd2, 32'd6, 0, 32'd0, 1'b0, "b2b_w2");
    xfer(1'b0, 32'd2, 32'd0, 0, 32'd6, 1'b0, "b2b_r2");
    idle_cycle("b2b_drop");

    // Access phase without setup must be ignored
    @(negedge clk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'd2; pwdata = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nosetup_pready", {31'd0, pready}, 32'd0);
    end
    idle_cycle("nosetup_exit");
    xfer(1'b0, 32'd2, 32'd0, 0, 32'd6, 1'b0, "nosetup_r2");
    idle_cycle("nosetup_drop");

    // Two wait states
    sel2 = 1'b1;
    xfer(1'b1, 32'd5, 32'hA5A5_A5A5, 2, 32'd0, 1'b0, "ws2_w5");
    xfer(1'b0, 32'd5, 32'd0, 2, 32'hA5A5_A5A5, 1'b0, "ws2_r5");
    idle_cycle("ws2_drop");

    // Abort in the first access cycle
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'd3; pwdata = 32'd4;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_pready", {31'd0, pready}, 32'd0);
    end
    xfer(1'b0, 32'd3, 32'd0, 2, 32'd0, 1'b0, "abort_r3");
    idle_cycle("abort_drop");

    // Reset in the access phase of a write
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'd4; pwdata = 32'd8;
    @(negedge clk);
    penable = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    check("mrst_pready2",  {31'd0, pready2},  32'd0);
    check("mrst_pslverr2", {31'd0, pslverr2}, 32'd0);
    check("mrst_prdata2",  prdata2,           32'd0);
    check("mrst_prdata0",  prdata0,           32'd0);
    xfer(1'b0, 32'd4, 32'd0, 2, 32'd0, 1'b0, "mrst_r4");
    xfer(1'b0, 32'd5, 32'd0, 2, 32'd0, 1'b0, "mrst_r5");
    idle_cycle("mrst_drop2");
    sel2 = 1'b0;
    xfer(1'b0, 32'd2, 32'd0, 0, 32'd0, 1'b0, "mrst_r2_ws0");
    idle_cycle("mrst_drop0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb_mem_slave.md
# apb_mem_slave

APB3 completer (slave) holding a small word-addressed register memory, with programmable wait states and error signalling. It is the responder for the team's APB master stimulus: it consumes PSEL/PENABLE/PWRITE/PADDR/PWDATA and returns PRDATA, PREADY and PSLVERR. It sits behind the APB decode as a single peripheral and is the bus-side endpoint for write/read-back traffic.

## Interface
- DATA_W, 32, width of PWDATA/PRDATA and of each memory word
- ADDR_W, 32, width of PADDR
- DEPTH, 16, number of memory words; valid word indices are 0..DEPTH-1
- WAIT_STATES, 1, number of access-phase cycles with PREADY=0 before completion (0 = zero-wait)
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- PADDR  input  ADDR_W  word index (not byte address); index 1 is the second word
- PSEL  input  1  peripheral select
- PENABLE  input  1  access-phase marker
- PWRITE  input  1  1 = write, 0 = read
- PWDATA  input  DATA_W  write data
- PRDATA  output  DATA_W  read data, valid while PREADY=1 on a read
- PREADY  output  1  transfer completes on the edge where PSEL&PENABLE&PREADY=1
- PSLVERR  output  1  error flag, meaningful only while PREADY=1

## Operation
- FSM states: IDLE, ACCESS. Wait counter width is clog2(WAIT_STATES+1), minimum 1.
- IDLE: on an edge with PSEL=1, PENABLE=0 (setup phase), capture PADDR, PWRITE, PWDATA; compute err = (PADDR >= DEPTH), using a full ADDR_W compare with no truncation; load cnt=WAIT_STATES; go to ACCESS.
- IDLE with PSEL=1, PENABLE=1 (no preceding setup) is ignored: stay in IDLE, PREADY stays 0.
- ACCESS: PREADY = (cnt==0), decoded from registers only, with no combinational path from inputs. While PSEL&PENABLE and cnt!=0, decrement cnt each edge.
- Completion edge (ACCESS, PSEL&PENABLE, cnt==0):
  - Write, not err: mem[addr] <= captured PWDATA.
  - Err: no memory change.
  - Go to IDLE.
- PSLVERR = err while PREADY=1; otherwise 0.
- Read data: PRDATA is registered and loaded at the setup edge with mem[PADDR], or 0 if err. It holds until the next setup edge. Captured values are held for the whole access phase, and the slave ignores PADDR/PWDATA changes after setup.
- Abort: PSEL=0 while in ACCESS returns the FSM to IDLE at that edge. No write occurs; PRDATA is unchanged.
- Back-to-back: the cycle after a completion edge may be a new setup phase. IDLE accepts it with no idle cycle required.

## Timing
- Reset (rst=1 at an edge):
  - FSM=IDLE, cnt=0, PREADY=0, PSLVERR=0, PRDATA=0.
  - All DEPTH memory words are cleared to 0.
  - An in-flight transfer is dropped with no write.
  - rst has priority over every other event.
- Transfer length is 2+WAIT_STATES cycles: setup, WAIT_STATES cycles with PREADY=0, then one cycle with PREADY=1.
- Written data is readable by a read whose setup edge comes after the write's completion edge. A back-to-back write then read of the same address returns the new data.
- PREADY is high for exactly one cycle per completed transfer. It drops in the cycle after completion.

## Test plan
- WAIT_STATES=0: write 7 to addr 1, write 3 to addr 2, then read addr 1 and addr 2.
  - Each transfer takes 2 cycles with PREADY=1 in its access cycle.
  - Reads return 7 and 3; PSLVERR=0 throughout.
- WAIT_STATES=2: write 0xA5A5A5A5 to addr 5, then read addr 5.
  - Exactly 2 access cycles with PREADY=0, then 1 with PREADY=1.
  - Read returns 0xA5A5A5A5.
- Out of range: write 9 to addr 16, then read addr 16 and read addr 0.
  - Both addr-16 transfers complete with PREADY=1 and PSLVERR=1; the read returns PRDATA=0.
  - Addr 0 still reads 0.
- Abort (WAIT_STATES=2): setup a write of 4 to addr 3, drop PSEL in the first access cycle.
  - FSM returns to IDLE.
  - A later read of addr 3 returns 0.
- Reset mid-transfer: write 8 to addr 4, assert rst in its access phase, then read addr 4.
  - After reset, PREADY=0, PSLVERR=0, PRDATA=0.
  - Read of addr 4 returns 0.
- Back-to-back (WAIT_STATES=0): write 6 to addr 2 with the next setup cycle immediately reading addr 2.
  - Read returns 6.
  - Setup with PENABLE=1 from IDLE produces no PREADY.
